// File: rtl/regf_pkg.sv
// Shared types and helpers for the multi-port integer register file.
package regf_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int ZERO_IDX = 0;

    typedef logic [$clog2(NREG_DEF)-1:0] reg_addr_t;
    typedef logic [XLEN_DEF-1:0]         reg_data_t;

    // Operand as seen by decode: value plus "producer still in flight" flag.
    typedef struct packed {
        reg_data_t data;
        logic      busy;
    } regvec_t;

    // A register index is live if it exists and is not the hardwired zero.
    function automatic logic addr_ok(input int a, input int nreg, input bit zero_reg);
        return (a < nreg) && !(zero_reg && a == ZERO_IDX);
    endfunction

endpackage

// File: rtl/regf_scoreboard.sv
// Per-register busy scoreboard: issue marks a destination busy, writeback
// clears it, flush clears everything. busy_next is exported so bypassed
// reads can see the same-edge result.
module regf_scoreboard
    import regf_pkg::*;
#(
    parameter  int NREG     = 32,
    parameter  int NWRITE   = 1,
    parameter  int ZERO_REG = 1,
    localparam int AW       = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NWRITE-1:0]  w_enable,
    input  logic [NWRITE*AW-1:0] w_addr,
    input  logic               issue_en,
    input  logic [AW-1:0]      issue_addr,
    input  logic               flush,
    output logic [NREG-1:0]    busy,
    output logic [NREG-1:0]    busy_next
);

    // Priority: flush, then writeback clears, then issue sets (issue wins).
    always_comb begin
        busy_next = busy;
        if (flush)
            busy_next = '0;
        for (int j = 0; j < NWRITE; j++) begin
            if (w_enable[j] && int'(w_addr[j*AW +: AW]) < NREG)
                busy_next[w_addr[j*AW +: AW]] = 1'b0;
        end
        if (issue_en && addr_ok(int'(issue_addr), NREG, ZERO_REG != 0))
            busy_next[issue_addr] = 1'b1;
    end

    // Busy vector register; reset drops all in-flight state.
    always_ff @(posedge clk) begin
        if (!rstn)
            busy <= '0;
        else
            busy <= busy_next;
    end

endmodule

// File: rtl/regf_mp.sv
// Multi-port integer register file: NREAD registered read ports, NWRITE
// write ports (highest port wins on collisions), optional write-to-read
// bypass, and a busy scoreboard whose flag tracks the same snapshot as data.
module regf_mp
    import regf_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEF,
    parameter  int NREG     = NREG_DEF,
    parameter  int NREAD    = 2,
    parameter  int NWRITE   = 1,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int AW       = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   r_enabled,
    input  logic [NREAD*AW-1:0]    rd_addr,
    output logic [NREAD*XLEN-1:0]  rd_data,
    output logic [NREAD-1:0]       rd_busy,
    input  logic [NWRITE-1:0]      w_enable,
    input  logic [NWRITE*AW-1:0]   w_addr,
    input  logic [NWRITE*XLEN-1:0] w_data,
    input  logic                   issue_en,
    input  logic [AW-1:0]          issue_addr,
    input  logic                   flush
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy, busy_next;
    logic [AW-1:0]   ra     [NREAD];
    logic [XLEN-1:0] rd_val [NREAD];
    logic            rd_bval[NREAD];

    regf_scoreboard #(
        .NREG     (NREG),
        .NWRITE   (NWRITE),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk        (clk),
        .rstn       (rstn),
        .w_enable   (w_enable),
        .w_addr     (w_addr),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .flush      (flush),
        .busy       (busy),
        .busy_next  (busy_next)
    );

    // Post-write value of register a this edge; later ports override earlier.
    function automatic logic [XLEN-1:0] merge_write(
        input logic [AW-1:0]          a,
        input logic [XLEN-1:0]        base,
        input logic [NWRITE-1:0]      en,
        input logic [NWRITE*AW-1:0]   wa,
        input logic [NWRITE*XLEN-1:0] wd
    );
        logic [XLEN-1:0] v;
        v = base;
        for (int j = 0; j < NWRITE; j++)
            if (en[j] && wa[j*AW +: AW] == a)
                v = wd[j*XLEN +: XLEN];
        return v;
    endfunction

    // Read muxes: zero/out-of-range read as 0 and never busy.
    always_comb begin
        for (int i = 0; i < NREAD; i++) begin
            ra[i]      = rd_addr[i*AW +: AW];
            rd_val[i]  = '0;
            rd_bval[i] = 1'b0;
            if (addr_ok(int'(ra[i]), NREG, ZERO_REG != 0)) begin
                if (BYPASS != 0) begin
                    rd_val[i]  = merge_write(ra[i], regs[ra[i]], w_enable, w_addr, w_data);
                    rd_bval[i] = busy_next[ra[i]];
                end else begin
                    rd_val[i]  = regs[ra[i]];
                    rd_bval[i] = busy[ra[i]];
                end
            end
        end
    end

    // Storage and registered read ports; ascending port loop makes the
    // highest write port the last assignment and therefore the winner.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < NREG; k++)
                regs[k] <= '0;
            rd_data <= '0;
            rd_busy <= '0;
        end else begin
            for (int j = 0; j < NWRITE; j++)
                if (w_enable[j] && addr_ok(int'(w_addr[j*AW +: AW]), NREG, ZERO_REG != 0))
                    regs[w_addr[j*AW +: AW]] <= w_data[j*XLEN +: XLEN];
            if (r_enabled) begin
                for (int i = 0; i < NREAD; i++) begin
                    rd_data[i*XLEN +: XLEN] <= rd_val[i];
                    rd_busy[i]              <= rd_bval[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_regf_mp.sv
// Bench for regf_mp: two instances share stimulus -- A (32 regs, zero reg,
// bypass) and B (24 regs, no zero reg, no bypass) -- each checked against
// an architectural model every cycle, plus directed spot checks.
module tb_regf_mp;

    logic        clk = 1'b0;
    logic        rstn;
    logic        r_en;
    logic [9:0]  rd_addr;
    logic [1:0]  w_enable;
    logic [9:0]  w_addr;
    logic [63:0] w_data;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic        flush;
    logic [63:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_busy_a, rd_busy_b;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    regf_mp #(.XLEN(32), .NREG(32), .NREAD(2), .NWRITE(2), .ZERO_REG(1), .BYPASS(1)) u_a (
        .clk(clk), .rstn(rstn), .r_enabled(r_en), .rd_addr(rd_addr),
        .rd_data(rd_data_a), .rd_busy(rd_busy_a), .w_enable(w_enable),
        .w_addr(w_addr), .w_data(w_data), .issue_en(issue_en),
        .issue_addr(issue_addr), .flush(flush));

    regf_mp #(.XLEN(32), .NREG(24), .NREAD(2), .NWRITE(2), .ZERO_REG(0), .BYPASS(0)) u_b (
        .clk(clk), .rstn(rstn), .r_enabled(r_en), .rd_addr(rd_addr),
        .rd_data(rd_data_b), .rd_busy(rd_busy_b), .w_enable(w_enable),
        .w_addr(w_addr), .w_data(w_data), .issue_en(issue_en),
        .issue_addr(issue_addr), .flush(flush));

    // Architectural model, index 0 = instance A, 1 = instance B.
    int          m_nreg [2] = '{32, 24};
    bit          m_zero [2] = '{1'b1, 1'b0};
    bit          m_byp  [2] = '{1'b1, 1'b0};
    logic [31:0] m_regs [2][32];
    bit          m_busy [2][32];
    logic [31:0] m_data [2][2];
    logic        m_bsy  [2][2];

    function automatic bit live(int m, int a);
        return a < m_nreg[m] && !(m_zero[m] && a == 0);
    endfunction

    task automatic model_edge();
        logic [31:0] nr [32];
        bit          nb [32];
        int          a;
        for (int m = 0; m < 2; m++) begin
            if (!rstn) begin
                for (int k = 0; k < 32; k++) begin m_regs[m][k] = '0; m_busy[m][k] = 1'b0; end
                for (int i = 0; i < 2; i++) begin m_data[m][i] = '0; m_bsy[m][i] = 1'b0; end
                continue;
            end
            for (int k = 0; k < 32; k++) begin nr[k] = m_regs[m][k]; nb[k] = m_busy[m][k]; end
            if (flush)
                for (int k = 0; k < 32; k++) nb[k] = 1'b0;
            for (int j = 0; j < 2; j++) begin
                a = int'(w_addr[j*5 +: 5]);
                if (w_enable[j] && live(m, a)) nr[a] = w_data[j*32 +: 32];
                if (w_enable[j] && a < m_nreg[m]) nb[a] = 1'b0;
            end
            a = int'(issue_addr);
            if (issue_en && live(m, a)) nb[a] = 1'b1;
            if (r_en) begin
                for (int i = 0; i < 2; i++) begin
                    a = int'(rd_addr[i*5 +: 5]);
                    if (!live(m, a)) begin
                        m_data[m][i] = '0; m_bsy[m][i] = 1'b0;
                    end else if (m_byp[m]) begin
                        m_data[m][i] = nr[a]; m_bsy[m][i] = nb[a];
                    end else begin
                        m_data[m][i] = m_regs[m][a]; m_bsy[m][i] = m_busy[m][a];
                    end
                end
            end
            for (int k = 0; k < 32; k++) begin m_regs[m][k] = nr[k]; m_busy[m][k] = nb[k]; end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("a.data%0d", i), rd_data_a[i*32 +: 32], m_data[0][i]);
            chk($sformatf("a.busy%0d", i), 32'(rd_busy_a[i]),     32'(m_bsy[0][i]));
            chk($sformatf("b.data%0d", i), rd_data_b[i*32 +: 32], m_data[1][i]);
            chk($sformatf("b.busy%0d", i), 32'(rd_busy_b[i]),     32'(m_bsy[1][i]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        rstn = 1'b1; r_en = 1'b0; rd_addr = '0; w_enable = '0; w_addr = '0;
        w_data = '0; issue_en = 1'b0; issue_addr = '0; flush = 1'b0;
    endtask

    task automatic wr(input int port, input logic [4:0] a, input logic [31:0] d);
        w_enable[port]        = 1'b1;
        w_addr[port*5 +: 5]   = a;
        w_data[port*32 +: 32] = d;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        r_en = 1'b1; rd_addr = {a1, a0};
    endtask

    initial begin
        idle();
        rstn = 1'b0;
        step(); step();
        chk("reset.a.data0", rd_data_a[31:0], 32'h0);
        chk("reset.b.busy", 32'(rd_busy_b), 32'h0);

        // reset mid-operation wipes written data
        idle(); wr(0, 5'd5, 32'h1234); step();
        idle(); rstn = 1'b0; step();
        idle(); rd(5'd5, 5'd5); step();
        chk("t1.a.x5", rd_data_a[31:0], 32'h0);
        chk("t1.a.busy", 32'(rd_busy_a[0]), 32'h0);

        // same-edge write/read: bypass vs old value
        idle(); wr(0, 5'd3, 32'h55); step();
        idle(); wr(0, 5'd3, 32'hDEADBEEF); rd(5'd3, 5'd0); step();
        chk("t2.a.byp", rd_data_a[31:0], 32'hDEADBEEF);
        chk("t2.b.old", rd_data_b[31:0], 32'h55);
        idle(); rd(5'd3, 5'd0); step();
        chk("t2.b.new", rd_data_b[31:0], 32'hDEADBEEF);

        // zero register
        idle(); wr(0, 5'd0, 32'hFFFFFFFF); issue_en = 1'b1; issue_addr = 5'd0; rd(5'd0, 5'd0); step();
        idle(); rd(5'd0, 5'd0); step();
        chk("t3.a.x0", rd_data_a[31:0], 32'h0);
        chk("t3.a.x0busy", 32'(rd_busy_a[0]), 32'h0);
        chk("t3.b.x0", rd_data_b[31:0], 32'hFFFFFFFF);

        // multi-port writes
        idle(); wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22); rd(5'd7, 5'd0); step();
        chk("t4.a.x7byp", rd_data_a[31:0], 32'h22);
        idle(); rd(5'd7, 5'd7); step();
        chk("t4.b.x7", rd_data_b[31:0], 32'h22);
        idle(); wr(0, 5'd8, 32'hA); wr(1, 5'd9, 32'hB); step();
        idle(); rd(5'd8, 5'd9); step();
        chk("t4.a.x8", rd_data_a[31:0], 32'hA);
        chk("t4.a.x9", rd_data_a[63:32], 32'hB);

        // scoreboard
        idle(); issue_en = 1'b1; issue_addr = 5'd4; step();
        idle(); rd(5'd4, 5'd4); step();
        chk("t5.issue", 32'(rd_busy_a[0]), 32'h1);
        idle(); wr(0, 5'd4, 32'h44); step();
        idle(); rd(5'd4, 5'd4); step();
        chk("t5.wrclr", 32'(rd_busy_a[0]), 32'h0);
        idle(); wr(1, 5'd4, 32'h45); issue_en = 1'b1; issue_addr = 5'd4; step();
        idle(); rd(5'd4, 5'd4); step();
        chk("t5.wr+issue", 32'(rd_busy_b[0]), 32'h1);
        idle(); flush = 1'b1; step();
        idle(); rd(5'd4, 5'd4); step();
        chk("t5.flush", 32'(rd_busy_a[0]), 32'h0);
        idle(); flush = 1'b1; issue_en = 1'b1; issue_addr = 5'd4; step();
        idle(); rd(5'd4, 5'd4); step();
        chk("t5.fl+issue", 32'(rd_busy_a[1]), 32'h1);

        // hold while r_enabled is low
        idle(); rd(5'd10, 5'd10); step();
        idle(); rd_addr = {5'd10, 5'd10}; wr(0, 5'd10, 32'h77); issue_en = 1'b1; issue_addr = 5'd10; step();
        chk("t6.hold.data", rd_data_a[31:0], 32'h0);
        chk("t6.hold.busy", 32'(rd_busy_a[0]), 32'h0);

        // random traffic against the model
        for (int n = 0; n < 10000; n++) begin
            rstn       = ($urandom_range(0, 299) != 0);
            r_en       = ($urandom_range(0, 3) != 0);
            w_enable   = 2'($urandom_range(0, 3));
            w_data     = {$urandom(), $urandom()};
            issue_en   = ($urandom_range(0, 2) == 0);
            flush      = ($urandom_range(0, 40) == 0);
            issue_addr = 5'($urandom_range(0, 31));
            for (int p = 0; p < 2; p++) begin
                w_addr[p*5 +: 5]  = 5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
                rd_addr[p*5 +: 5] = 5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
